// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame geometry and the odd-parity helper.
// Used by the host transmitter and the system-clocked receiver.
package ps2_pkg;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_FRAME_EDGES = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins, plus a falling-edge
// strobe on the synchronized clock. Everything resets to the idle-high level.
module ps2_line_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic clock_sync,
    output logic data_sync,
    output logic clock_fe
);

    logic clk_meta_r;
    logic clk_sync_r;
    logic clk_prev_r;
    logic dat_meta_r;
    logic dat_sync_r;

    // Synchronizer chains and one-cycle history of the synced clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clock;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_data;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign clock_sync = clk_sync_r;
    assign data_sync  = dat_sync_r;
    assign clock_fe   = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts a byte
// out on device-generated clock edges and checks the device acknowledge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       ps2_clock_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int PH_MAX  = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FRAME_W = PS2_DATA_BITS + 2;

    logic               clock_sync_s;
    logic               data_sync_s;
    logic               clock_fe_s;
    logic               wd_expired_s;

    ps2_state_e         state_r;
    logic [FRAME_W-1:0] shift_r;
    logic [3:0]         bit_cnt_r;
    logic [PH_W-1:0]    phase_cnt_r;
    logic [WD_W-1:0]    wd_r;
    logic               clk_low_r;
    logic               data_low_r;
    logic               tx_ready_r;
    logic               done_r;
    logic               error_r;

    ps2_line_sync u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clock  (ps2_clock),
        .ps2_data   (ps2_data),
        .clock_sync (clock_sync_s),
        .data_sync  (data_sync_s),
        .clock_fe   (clock_fe_s)
    );

    assign wd_expired_s = (wd_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Transmit FSM; every pin-facing and handshake output is registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            shift_r     <= {FRAME_W{1'b1}};
            bit_cnt_r   <= 4'd0;
            phase_cnt_r <= {PH_W{1'b0}};
            wd_r        <= {WD_W{1'b0}};
            clk_low_r   <= 1'b0;
            data_low_r  <= 1'b0;
            tx_ready_r  <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    clk_low_r   <= 1'b0;
                    data_low_r  <= 1'b0;
                    bit_cnt_r   <= 4'd0;
                    phase_cnt_r <= {PH_W{1'b0}};
                    wd_r        <= {WD_W{1'b0}};
                    if (tx_valid && tx_ready_r) begin
                        shift_r    <= {1'b1, ps2_odd_parity(tx_data), tx_data};
                        clk_low_r  <= 1'b1;
                        tx_ready_r <= 1'b0;
                        state_r    <= INHIBIT;
                    end else begin
                        tx_ready_r <= 1'b1;
                    end
                end
                INHIBIT: begin
                    if (phase_cnt_r == PH_W'(INHIBIT_CYCLES - 1)) begin
                        phase_cnt_r <= {PH_W{1'b0}};
                        data_low_r  <= 1'b1;
                        state_r     <= RTS;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_W'(1);
                    end
                end
                RTS: begin
                    if (phase_cnt_r == PH_W'(RTS_CYCLES - 1)) begin
                        phase_cnt_r <= {PH_W{1'b0}};
                        clk_low_r   <= 1'b0;
                        wd_r        <= {WD_W{1'b0}};
                        bit_cnt_r   <= 4'd0;
                        state_r     <= SEND;
                    end else begin
                        phase_cnt_r <= phase_cnt_r + PH_W'(1);
                    end
                end
                SEND: begin
                    // The stop bit (1) ends up in shift_r[0] on the tenth edge, releasing data.
                    if (clock_fe_s) begin
                        wd_r       <= {WD_W{1'b0}};
                        data_low_r <= ~shift_r[0];
                        shift_r    <= {1'b1, shift_r[FRAME_W-1:1]};
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'(PS2_FRAME_EDGES - 1)) begin
                            state_r <= ACK;
                        end else begin
                            state_r <= SEND;
                        end
                    end else if (wd_expired_s) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        error_r    <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                ACK: begin
                    if (clock_fe_s) begin
                        wd_r <= {WD_W{1'b0}};
                        if (!data_sync_s) begin
                            state_r <= WAIT_IDLE;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else if (wd_expired_s) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        error_r    <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (clock_sync_s && data_sync_s) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else if (clock_fe_s) begin
                        wd_r <= {WD_W{1'b0}};
                    end else if (wd_expired_s) begin
                        clk_low_r  <= 1'b0;
                        data_low_r <= 1'b0;
                        error_r    <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        wd_r <= wd_r + WD_W'(1);
                    end
                end
                default: begin
                    clk_low_r  <= 1'b0;
                    data_low_r <= 1'b0;
                    tx_ready_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready            = tx_ready_r;
    assign busy                = ~tx_ready_r;
    assign ps2_clock_drive_low = clk_low_r;
    assign ps2_data_drive_low  = data_low_r;
    assign tx_done             = done_r;
    assign tx_error            = error_r;

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. Sends command bytes such as 0xED (set LEDs) and 0xFF (reset) from the system to the keyboard. Runs on the system clock and oversamples the device-generated PS/2 clock. Drives both open-drain PS/2 lines through active-high pull-low enables. Sits beside the PS/2 receive path on the same two wires; the top level gates the receiver while `busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 5000: cycles the clock line is held low before request-to-send (100 µs at 50 MHz).
- `RTS_CYCLES`, default 50: cycles data and clock are both held low before the clock is released.
- `TIMEOUT_CYCLES`, default 750000: watchdog limit in cycles (15 ms at 50 MHz). Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

- `clock` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: request to send `tx_data`.
- `tx_ready` output 1: high only in IDLE. A byte is accepted on a cycle where `tx_valid` and `tx_ready` are both high.
- `ps2_clock` input 1: raw PS/2 clock pin; asynchronous.
- `ps2_data` input 1: raw PS/2 data pin; asynchronous.
- `ps2_clock_drive_low` output 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_drive_low` output 1: 1 pulls the data line low; 0 releases it.
- `busy` output 1: equal to `!tx_ready`.
- `tx_done` output 1: one-cycle pulse when the device acknowledges and the bus returns to idle.
- `tx_error` output 1: one-cycle pulse on watchdog expiry or missing ack.

## Operation
- **Line sampling:** both lines pass through 2-FF synchronizers. A falling edge `fe` is synced clock previous=1 and current=0.
- **Reset:** async reset forces IDLE.
  - Outputs: both drive_low = 0, `tx_ready` = 1, `busy` = 0, `tx_done` = `tx_error` = 0.
  - Internal: bit counter = 0, watchdog = 0, synchronizers = 1.
  - Reset mid-frame releases both lines immediately; no partial byte is retried.
- **Acceptance:** on accept, latch the shift register {stop=1, parity=~^tx_data, tx_data} and go to INHIBIT.
- **State machine:**
  - IDLE: lines released; PS/2 activity is ignored.
  - INHIBIT: clock_drive_low=1, data released, for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: clock_drive_low=1 and data_drive_low=1 for RTS_CYCLES cycles, then go to SEND.
  - SEND: clock released; data holds the start bit (low). On each `fe`, with k counting 1..10:
    - fe 1–8: drive data bits 0–7, LSB first. drive_low = ~bit.
    - fe 9: drive the parity bit.
    - fe 10: release data (stop bit), then go to ACK.
  - ACK: on the next `fe`, sample synced data. 0 = ack → WAIT_IDLE. 1 = no ack → pulse `tx_error`, go to IDLE.
  - WAIT_IDLE: wait until synced clock and synced data are both 1, then pulse `tx_done` and go to IDLE.
- **Watchdog:**
  - Cleared on entry to SEND and on every `fe`. Runs in SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse `tx_error`, go to IDLE.
  - Watchdog expiry and `fe` in the same cycle: the edge wins.
- **Edge cases:**
  - `tx_valid` while busy is ignored, and `tx_data` changes while busy have no effect.
  - `tx_done` and `tx_error` are mutually exclusive.

## Timing
- Accept to clock pulled low: 1 cycle; drive_low is a registered output.
- Clock low duration: INHIBIT_CYCLES + RTS_CYCLES. Data low starts INHIBIT_CYCLES cycles after clock low.
- Pin falling edge to data output change: 3 cycles (2 synchronizer stages + registered output). This is well inside the device's clock-low half period.
- Back-to-back sends: `tx_ready` rises the cycle after `tx_done`/`tx_error`, so a new accept is possible that cycle.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE};
  - `PS2_DATA_BITS`=8 and `PS2_FRAME_EDGES`=10;
  - an odd-parity function.
  The future system-clocked receiver reuses it.
- Sub-module `ps2_line_sync`: 2-FF synchronizer for clock and data, plus falling-edge detect. Its reset value is 1.

## Test plan
- Send 0xED with the device model clocking at 12.5 kHz → start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Ack given → one `tx_done` pulse.
- Send 0x01 → parity 0. Send 0xFF → parity 1. Device-side parity check passes for both.
- Device never clocks after RTS → `tx_error` exactly TIMEOUT_CYCLES after SEND entry. Lines released; `tx_ready`=1.
- Device withholds ack (data high at edge 11) → `tx_error`, no `tx_done`.
- `reset_n` asserted at edge 5 of a frame → both drive_low = 0 the same cycle (async). A following send of 0xF4 completes normally.
- `tx_valid` held high with changing `tx_data` during a frame → only the first byte is sent. The second accept occurs the cycle after `tx_done`.
